// File: rtl/mult_booth_32bit_pkg.sv
// Shared constants and types for the radix-2 Booth multiplier.
package mult_booth_32bit_pkg;

    localparam int WIDTH = 32;
    localparam int STEPS = 32;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    typedef enum logic [1:0] {
        BOOTH_NOP = 2'b00,
        BOOTH_ADD = 2'b01,
        BOOTH_SUB = 2'b10
    } booth_sel_t;

    // Radix-2 Booth recoding of {Q[0], q_m1}.
    function automatic booth_sel_t booth_decode(input logic q0, input logic q_m1);
        case ({q0, q_m1})
            2'b10:   return BOOTH_SUB;
            2'b01:   return BOOTH_ADD;
            default: return BOOTH_NOP;
        endcase
    endfunction

endpackage

// File: rtl/adder_32bit.sv
// 32-bit carry-select adder built from four 8-bit blocks, with signed overflow.
module adder_32bit (
    input  logic [31:0] ina,
    input  logic [31:0] inb,
    input  logic        carry_in,
    output logic [31:0] sum,
    output logic        overflow
);

    logic [4:0] blk_carry;

    assign blk_carry[0] = carry_in;

    for (genvar gi = 0; gi < 4; gi++) begin : g_blk
        logic [8:0] sum_c0;
        logic [8:0] sum_c1;

        // Both carry-in candidates are formed in parallel; the real carry selects.
        assign sum_c0 = {1'b0, ina[gi*8 +: 8]} + {1'b0, inb[gi*8 +: 8]};
        assign sum_c1 = {1'b0, ina[gi*8 +: 8]} + {1'b0, inb[gi*8 +: 8]} + 9'd1;

        assign sum[gi*8 +: 8]   = blk_carry[gi] ? sum_c1[7:0] : sum_c0[7:0];
        assign blk_carry[gi+1]  = blk_carry[gi] ? sum_c1[8]   : sum_c0[8];
    end

    // Carry into bit 31 is recovered as sum ^ ina ^ inb at that bit.
    assign overflow = blk_carry[4] ^ sum[31] ^ ina[31] ^ inb[31];

endmodule

// File: rtl/mult_booth_step.sv
// One combinational radix-2 Booth step: add/sub via adder_32bit, then arithmetic shift.
module mult_booth_step
    import mult_booth_32bit_pkg::*;
(
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] m,
    input  logic             q0,
    input  logic             q_m1,
    output logic [WIDTH-1:0] a_next,
    output logic             shift_bit
);

    logic [WIDTH-1:0] add_inb;
    logic             add_cin;
    logic [WIDTH-1:0] sum;
    logic             add_ovf;
    logic             ext;

    always_comb begin
        add_inb = '0;
        add_cin = 1'b0;
        case (booth_decode(q0, q_m1))
            BOOTH_SUB: begin
                add_inb = ~m;
                add_cin = 1'b1;
            end
            BOOTH_ADD: begin
                add_inb = m;
                add_cin = 1'b0;
            end
            default: begin
                add_inb = '0;
                add_cin = 1'b0;
            end
        endcase
    end

    adder_32bit u_adder (
        .ina      (a),
        .inb      (add_inb),
        .carry_in (add_cin),
        .sum      (sum),
        .overflow (add_ovf)
    );

    // True 33-bit sign of the sum, so the shift stays exact even for M = -2^31.
    assign ext       = sum[WIDTH-1] ^ add_ovf;
    assign a_next    = {ext, sum[WIDTH-1:1]};
    assign shift_bit = sum[0];

endmodule

// File: rtl/mult_booth_32bit.sv
// Multi-cycle signed 32x32 Booth multiplier: one step per clock, low word plus overflow flag.
module mult_booth_32bit
    import mult_booth_32bit_pkg::*;
(
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic [WIDTH-1:0] result,
    output logic             overflow,
    output logic             result_rdy
);

    state_t           state;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] q_reg;
    logic             q_m1_reg;
    logic [WIDTH-1:0] m_reg;
    logic [4:0]       count_reg;

    logic [WIDTH-1:0] a_next;
    logic             shift_bit;
    logic [WIDTH-1:0] q_next;

    mult_booth_step u_step (
        .a         (a_reg),
        .m         (m_reg),
        .q0        (q_reg[0]),
        .q_m1      (q_m1_reg),
        .a_next    (a_next),
        .shift_bit (shift_bit)
    );

    assign q_next = {shift_bit, q_reg[WIDTH-1:1]};

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            busy       <= 1'b0;
            result     <= '0;
            overflow   <= 1'b0;
            result_rdy <= 1'b0;
            a_reg      <= '0;
            q_reg      <= '0;
            q_m1_reg   <= 1'b0;
            m_reg      <= '0;
            count_reg  <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    result_rdy <= 1'b0;
                    if (start) begin
                        a_reg     <= '0;
                        q_reg     <= op_b;
                        q_m1_reg  <= 1'b0;
                        m_reg     <= op_a;
                        count_reg <= '0;
                        busy      <= 1'b1;
                        state     <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    a_reg    <= a_next;
                    q_reg    <= q_next;
                    q_m1_reg <= q_reg[0];
                    if (count_reg == 5'(STEPS - 1)) begin
                        // Product fits only if the high word is pure sign extension of the low word.
                        result     <= q_next;
                        overflow   <= (a_next != {WIDTH{q_next[WIDTH-1]}});
                        result_rdy <= 1'b1;
                        busy       <= 1'b0;
                        state      <= DONE;
                    end else begin
                        count_reg <= count_reg + 5'd1;
                    end
                end
                default: begin
                    busy       <= 1'b0;
                    result_rdy <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule
